// File: rtl/tri_bus_pkg.sv
// Shared encodings and sizing helpers for the tri-state bus driver.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  // Turnaround gap is limited to 0..7, so a 3-bit counter always suffices.
  localparam int TURN_W = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tri_bus_driver_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [IW-1:0]  win,
  output logic           any
);

  logic [IW:0] w_idx;

  // Scan last+1 .. last+NCH (mod NCH); the first hit wins, later hits are ignored.
  always_comb begin
    win   = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = {1'b0, last} + (IW+1)'(i);
      w_idx = (w_idx >= (IW+1)'(NCH)) ? (w_idx - (IW+1)'(NCH)) : w_idx;
      win   = (!any && req[w_idx[IW-1:0]]) ? w_idx[IW-1:0] : win;
      any   = any | req[w_idx[IW-1:0]];
    end
  end

endmodule

// File: rtl/tri_bus_driver.sv
// Multi-channel tri-state bus driver: round-robin ownership, registered drive
// stage, programmable turnaround gap and per-grant hold limit.
module tri_bus_driver
  import tri_bus_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] data_in,
  output logic [NCH-1:0]       grant,
  inout  wire  [WIDTH-1:0]     bus,
  output logic                 bus_oe,
  output logic                 busy
);

  localparam int IW = (NCH > 1) ? clog2(NCH) : 1;
  localparam int HW = clog2(MAXHOLD + 1);
  localparam logic [TURN_W-1:0] TURN_C = TURN_W'(TURN);

  state_e              r_state;
  logic [NCH-1:0]      r_grant;
  logic                r_bus_oe;
  logic [WIDTH-1:0]    r_dout;
  logic [HW-1:0]       r_hold_cnt;
  logic [TURN_W-1:0]   r_turn_cnt;
  logic [IW-1:0]       r_last;
  logic                r_busy;

  state_e              w_state_nxt;
  logic [NCH-1:0]      w_grant_nxt;
  logic                w_oe_nxt;
  logic [WIDTH-1:0]    w_dout_nxt;
  logic [HW-1:0]       w_hold_nxt;
  logic [TURN_W-1:0]   w_turn_nxt;
  logic [IW-1:0]       w_last_nxt;

  logic [IW-1:0]       w_win;
  logic                w_any;
  logic [NCH-1:0]      w_win_onehot;
  logic [WIDTH-1:0]    w_win_data;
  logic [WIDTH-1:0]    w_own_data;

  rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_pick (
    .req  (req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  // The current owner is always r_last, since every grant also updates it.
  assign w_win_onehot = NCH'(1) << w_win;
  assign w_win_data   = data_in[w_win*WIDTH +: WIDTH];
  assign w_own_data   = data_in[r_last*WIDTH +: WIDTH];

  // Next-state, grant and datapath selection.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_oe_nxt    = r_bus_oe;
    w_dout_nxt  = r_dout;
    w_hold_nxt  = r_hold_cnt;
    w_turn_nxt  = r_turn_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_DRIVE;
          w_grant_nxt = w_win_onehot;
          w_oe_nxt    = 1'b1;
          w_dout_nxt  = w_win_data;
          w_hold_nxt  = HW'(1);
          w_last_nxt  = w_win;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (req[r_last] && (r_hold_cnt < HW'(MAXHOLD))) begin
          w_dout_nxt = w_own_data;
          w_hold_nxt = r_hold_cnt + HW'(1);
        end else if (TURN_C != '0) begin
          w_state_nxt = S_TURN;
          w_grant_nxt = '0;
          w_oe_nxt    = 1'b0;
          w_turn_nxt  = TURN_W'(1);
        end else if (w_any) begin
          // Zero-gap handoff: bus_oe stays high, the new owner's word lands next cycle.
          w_state_nxt = S_DRIVE;
          w_grant_nxt = w_win_onehot;
          w_oe_nxt    = 1'b1;
          w_dout_nxt  = w_win_data;
          w_hold_nxt  = HW'(1);
          w_last_nxt  = w_win;
        end else begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_oe_nxt    = 1'b0;
        end
      end
      S_TURN: begin
        if (r_turn_cnt != TURN_C) begin
          w_turn_nxt = r_turn_cnt + TURN_W'(1);
        end else if (w_any) begin
          w_state_nxt = S_DRIVE;
          w_grant_nxt = w_win_onehot;
          w_oe_nxt    = 1'b1;
          w_dout_nxt  = w_win_data;
          w_hold_nxt  = HW'(1);
          w_last_nxt  = w_win;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_oe_nxt    = 1'b0;
      end
    endcase
  end

  // State, counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_bus_oe   <= 1'b0;
      r_dout     <= '0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_last     <= IW'(NCH - 1);
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_bus_oe   <= w_oe_nxt;
      r_dout     <= w_dout_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign grant  = r_grant;
  assign bus_oe = r_bus_oe;
  assign busy   = r_busy;
  assign bus    = r_bus_oe ? r_dout : {WIDTH{1'bz}};

endmodule
